// File: rtl/pwm_channel_scheduler.sv
// pwm_channel_scheduler: queues decoded UART channel commands, drives the
// per-channel PWM enables and emits one status record per command and per
// channel completion.
// Optional feature macro: SCHED_WATCHDOG_EN adds a per-channel enable watchdog
// that reports code 0xE4.

package pwm_channel_scheduler_pkg;
    typedef struct packed {
        logic [7:0] ch;
        logic [1:0] op;
    } sched_cmd_t;

    typedef enum logic [1:0] {ST_IDLE, ST_DECODE, ST_ARM, ST_RESP} sched_state_t;

    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_STOP  = 2'd1;

    localparam logic [7:0] CODE_STARTED = 8'h00;
    localparam logic [7:0] CODE_STOPPED = 8'h01;
    localparam logic [7:0] CODE_DONE    = 8'h02;
    localparam logic [7:0] CODE_IDLE    = 8'h03;
    localparam logic [7:0] CODE_ACTIVE  = 8'h04;
    localparam logic [7:0] CODE_BAD_CH  = 8'hE1;
    localparam logic [7:0] CODE_BUSY    = 8'hE2;
    localparam logic [7:0] CODE_ARM_TO  = 8'hE3;
`ifdef SCHED_WATCHDOG_EN
    localparam logic [7:0] CODE_WDOG    = 8'hE4;
`endif
endpackage

module pwm_channel_scheduler
    import pwm_channel_scheduler_pkg::*;
#(
    parameter int unsigned _NUM_CHANNELS = 3,
    parameter int unsigned _FIFO_DEPTH   = 4,
    parameter int unsigned _ARM_TO       = 16,
    parameter int unsigned _WDOG_W       = 24
) (
    input  logic                     clk_50M,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [7:0]               cmd_ch,
    input  logic [1:0]               cmd_op,
    input  logic [_NUM_CHANNELS-1:0] ch_busy,
    input  logic [_NUM_CHANNELS-1:0] ch_valid,
    output logic [_NUM_CHANNELS-1:0] ch_en,
    output logic                     stat_valid,
    input  logic                     stat_ready,
    output logic [7:0]               stat_ch,
    output logic [7:0]               stat_code,
    output logic [2:0]               fifo_level
);
    localparam int unsigned PTR_W = (_FIFO_DEPTH > 1) ? $clog2(_FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned IDX_W = (_NUM_CHANNELS > 1) ? $clog2(_NUM_CHANNELS) : 1;
    localparam int unsigned ARM_W = (_ARM_TO > 1) ? $clog2(_ARM_TO) : 1;

    sched_state_t             state_q, state_d;
    sched_cmd_t               cmd_q, cmd_d, cmd_in;
    sched_cmd_t               mem_q [_FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]         count_q;
    logic [ARM_W-1:0]         arm_cnt_q, arm_cnt_d;
    logic [_NUM_CHANNELS-1:0] ch_en_q, ch_en_d;
    logic [_NUM_CHANNELS-1:0] pend_done_q, pend_done_d;
    logic [IDX_W-1:0]         rr_q, rr_d;
    logic                     stat_valid_q, stat_valid_d;
    logic [7:0]               stat_ch_q, stat_ch_d;
    logic [7:0]               stat_code_q, stat_code_d;
    logic                     fifo_full, fifo_empty, push, pop_c;
    logic [IDX_W-1:0]         cmd_idx, rep_idx;
    logic [IDX_W:0]           done_pick, rep_pick;

    // Round-robin pick: {hit, index} of the first set flag at or after ptr.
    function automatic logic [IDX_W:0] rr_pick(input logic [_NUM_CHANNELS-1:0] flags,
                                               input logic [IDX_W-1:0] ptr);
        logic             hit;
        logic [IDX_W-1:0] idx;
        int               j;
        hit = 1'b0;
        idx = '0;
        for (int k = 0; k < int'(_NUM_CHANNELS); k++) begin
            j = int'(ptr) + k;
            if (j >= int'(_NUM_CHANNELS)) j = j - int'(_NUM_CHANNELS);
            if (!hit && flags[IDX_W'(j)]) begin
                hit = 1'b1;
                idx = IDX_W'(j);
            end
        end
        return {hit, idx};
    endfunction

    assign fifo_full   = (count_q == CNT_W'(_FIFO_DEPTH));
    assign fifo_empty  = (count_q == '0);
    assign push        = cmd_valid & ~fifo_full;
    assign cmd_in.ch   = cmd_ch;
    assign cmd_in.op   = cmd_op;
    assign cmd_idx     = IDX_W'(cmd_q.ch);
    assign done_pick   = rr_pick(pend_done_q, rr_q);

`ifdef SCHED_WATCHDOG_EN
    logic [_WDOG_W-1:0]       wdog_q [_NUM_CHANNELS];
    logic [_NUM_CHANNELS-1:0] pend_wdog_q, pend_wdog_d, wdog_hit_c;
    logic [IDX_W:0]           wdog_pick;
    logic                     rep_wdog;

    assign wdog_pick = rr_pick(pend_wdog_q, rr_q);
    assign rep_wdog  = wdog_pick[IDX_W];
    assign rep_pick  = rep_wdog ? wdog_pick : done_pick;

    // Watchdog expiry: counter saturated while the channel is still enabled.
    always_comb begin
        for (int i = 0; i < int'(_NUM_CHANNELS); i++) begin
            wdog_hit_c[i] = ch_en_q[i] && (wdog_q[i] == '1);
        end
    end

    // Per-channel enable-time counters, cleared whenever the enable is low.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(_NUM_CHANNELS); i++) wdog_q[i] <= '0;
        end else begin
            for (int i = 0; i < int'(_NUM_CHANNELS); i++) begin
                if (!ch_en_q[i])          wdog_q[i] <= '0;
                else if (wdog_q[i] != '1) wdog_q[i] <= wdog_q[i] + _WDOG_W'(1);
            end
        end
    end
`else
    assign rep_pick = done_pick;
`endif

    assign rep_idx = rep_pick[IDX_W-1:0];

    // Command FIFO storage (no reset needed, occupancy is tracked by count_q).
    always_ff @(posedge clk_50M) begin
        if (push) mem_q[wr_ptr_q] <= cmd_in;
    end

    // Command FIFO pointers and occupancy.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push)  wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop_c)      count_q <= count_q + CNT_W'(1);
            else if (!push && pop_c) count_q <= count_q - CNT_W'(1);
        end
    end

    // Scheduler state and output registers.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cmd_q        <= '0;
            arm_cnt_q    <= '0;
            ch_en_q      <= '0;
            pend_done_q  <= '0;
            rr_q         <= '0;
            stat_valid_q <= 1'b0;
            stat_ch_q    <= '0;
            stat_code_q  <= '0;
`ifdef SCHED_WATCHDOG_EN
            pend_wdog_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            arm_cnt_q    <= arm_cnt_d;
            ch_en_q      <= ch_en_d;
            pend_done_q  <= pend_done_d;
            rr_q         <= rr_d;
            stat_valid_q <= stat_valid_d;
            stat_ch_q    <= stat_ch_d;
            stat_code_q  <= stat_code_d;
`ifdef SCHED_WATCHDOG_EN
            pend_wdog_q  <= pend_wdog_d;
`endif
        end
    end

    // Next-state: completions first, then FSM actions (a stop overrides a completion).
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        arm_cnt_d    = arm_cnt_q;
        ch_en_d      = ch_en_q;
        pend_done_d  = pend_done_q;
        rr_d         = rr_q;
        stat_valid_d = stat_valid_q;
        stat_ch_d    = stat_ch_q;
        stat_code_d  = stat_code_q;
        pop_c        = 1'b0;
`ifdef SCHED_WATCHDOG_EN
        pend_wdog_d  = pend_wdog_q | wdog_hit_c;
        ch_en_d      = ch_en_d & ~wdog_hit_c;
`endif

        for (int i = 0; i < int'(_NUM_CHANNELS); i++) begin
            if (ch_valid[i] && ch_en_q[i]) begin
                ch_en_d[i]     = 1'b0;
                pend_done_d[i] = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (rep_pick[IDX_W]) begin
`ifdef SCHED_WATCHDOG_EN
                    if (rep_wdog) begin
                        pend_wdog_d[rep_idx] = 1'b0;
                        stat_code_d          = CODE_WDOG;
                    end else
`endif
                    begin
                        pend_done_d[rep_idx] = 1'b0;
                        stat_code_d          = CODE_DONE;
                    end
                    stat_valid_d = 1'b1;
                    stat_ch_d    = 8'(rep_idx);
                    rr_d         = (rep_idx == IDX_W'(_NUM_CHANNELS - 1)) ? '0
                                                                          : rep_idx + IDX_W'(1);
                    state_d      = ST_RESP;
                end else if (!fifo_empty) begin
                    pop_c   = 1'b1;
                    cmd_d   = mem_q[rd_ptr_q];
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                stat_valid_d = 1'b1;
                stat_ch_d    = cmd_q.ch;
                state_d      = ST_RESP;
                if (cmd_q.ch >= 8'(_NUM_CHANNELS)) begin
                    stat_code_d = CODE_BAD_CH;
                end else if (cmd_q.op == OP_START) begin
                    if (ch_en_q[cmd_idx] || ch_busy[cmd_idx]) begin
                        stat_code_d = CODE_BUSY;
                    end else begin
                        ch_en_d[cmd_idx] = 1'b1;
                        arm_cnt_d        = '0;
                        stat_valid_d     = 1'b0;
                        state_d          = ST_ARM;
                    end
                end else if (cmd_q.op == OP_STOP) begin
                    ch_en_d[cmd_idx]     = 1'b0;
                    pend_done_d[cmd_idx] = 1'b0;
`ifdef SCHED_WATCHDOG_EN
                    pend_wdog_d[cmd_idx] = 1'b0;
`endif
                    stat_code_d          = CODE_STOPPED;
                end else begin
                    stat_code_d = (ch_en_q[cmd_idx] || ch_busy[cmd_idx]) ? CODE_ACTIVE
                                                                         : CODE_IDLE;
                end
            end
            ST_ARM: begin
                if (ch_busy[cmd_idx]) begin
                    stat_valid_d = 1'b1;
                    stat_ch_d    = cmd_q.ch;
                    stat_code_d  = CODE_STARTED;
                    state_d      = ST_RESP;
                end else if (arm_cnt_q == ARM_W'(_ARM_TO - 1)) begin
                    ch_en_d[cmd_idx] = 1'b0;
                    stat_valid_d     = 1'b1;
                    stat_ch_d        = cmd_q.ch;
                    stat_code_d      = CODE_ARM_TO;
                    state_d          = ST_RESP;
                end else begin
                    arm_cnt_d = arm_cnt_q + ARM_W'(1);
                end
            end
            ST_RESP: begin
                if (stat_ready) begin
                    stat_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cmd_ready  = ~fifo_full;
    assign ch_en      = ch_en_q;
    assign stat_valid = stat_valid_q;
    assign stat_ch    = stat_ch_q;
    assign stat_code  = stat_code_q;
    assign fifo_level = 3'(count_q);

endmodule
